// File: rtl/matmult_scheduler.sv
// Round-robin scheduler for the 4x4x16b matrix-multiply engine: grants one of two
// requesters, sequences clear/load A/load B, waits for done with timeout, returns a tagged response.
module matmult_scheduler #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [255:0]      req0_a,
  input  logic [255:0]      req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [255:0]      req1_a,
  input  logic [255:0]      req1_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [255:0]      resp_data,
  output logic              resp_err,
  output logic              busy,
  output logic [CNT_W-1:0]  job_count,
  output logic [255:0]      eng_data,
  output logic              eng_load,
  output logic              eng_clear,
  input  logic              eng_done,
  input  logic [255:0]      eng_result
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD_A, S_LOAD_B, S_WAIT, S_RESP
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t        state, state_nxt;
  logic          last;
  logic          gnt;
  logic          any_req;
  logic          tmo_hit;
  logic [255:0]  a_q, b_q;
  logic [15:0]   tmo_cnt;

  // On a tie the grant goes to whoever was not served last.
  assign any_req = req0_valid | req1_valid;
  assign gnt     = (req0_valid & req1_valid) ? ~last : ~req0_valid;
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!nReset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (any_req) state_nxt = S_CLEAR;
      S_CLEAR:  state_nxt = S_LOAD_A;
      S_LOAD_A: state_nxt = S_LOAD_B;
      S_LOAD_B: state_nxt = S_WAIT;
      S_WAIT:   if (eng_done || tmo_hit) state_nxt = S_RESP;
      S_RESP:   if (resp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    resp_valid = 1'b0;
    eng_clear  = 1'b0;
    eng_load   = 1'b0;
    eng_data   = '0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        req0_ready = nReset & any_req & ~gnt;
        req1_ready = nReset & any_req &  gnt;
      end
      S_CLEAR:  eng_clear = 1'b1;
      S_LOAD_A: begin
        eng_load = 1'b1;
        eng_data = a_q;
      end
      S_LOAD_B: begin
        eng_load = 1'b1;
        eng_data = b_q;
      end
      S_RESP:   resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      last      <= 1'b1;
      resp_id   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      tmo_cnt   <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
      job_count <= '0;
    end else begin
      case (state)
        S_IDLE: if (any_req) begin
          a_q     <= gnt ? req1_a : req0_a;
          b_q     <= gnt ? req1_b : req0_b;
          resp_id <= gnt;
          last    <= gnt;
        end
        S_LOAD_B: tmo_cnt <= '0;
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          // done takes priority over a timeout landing in the same cycle
          if (eng_done) begin
            resp_data <= eng_result;
            resp_err  <= 1'b0;
          end else if (tmo_hit) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
          end
        end
        S_RESP: if (resp_ready) job_count <= job_count + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/matmult_scheduler.md
# matmult_scheduler

Sequencing and arbitration controller for the 4x4 16-bit matrix-multiply engine. Two requesters each submit an operand pair (A, B) as packed 256-bit matrices. The scheduler grants the engine round-robin, clears its accumulator, presents A then B on the engine bus, waits for completion with a timeout, and returns the product on a shared, tagged response channel. It sits between the command front-end and the engine, and is the only master of the engine bus.

## Interface
Parameters:
- TIMEOUT_CYC, 64: max cycles spent in WAIT before aborting the job (legal range 1..65535).
- CNT_W, 16: width of the completed-job counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- nReset  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- req0_valid  in  1  requester 0 has a job.
- req0_ready  out  1  requester 0 job accepted this cycle when valid&ready.
- req0_a, req0_b  in  256 each  operands; element [i][j] at bits i*64+16*j +:16.
- req1_valid, req1_ready, req1_a, req1_b: same as requester 0.
- resp_valid  out  1  response held until accepted.
- resp_ready  in  1  consumer accepts response.
- resp_id  out  1  requester that owns the response.
- resp_data  out  256  product, same packing as operands.
- resp_err  out  1  job aborted by timeout; resp_data is 0.
- busy  out  1  high in any state except IDLE.
- job_count  out  CNT_W  number of responses accepted (valid&ready) since reset.
- eng_data  out  256  operand bus to engine.
- eng_load  out  1  one-cycle strobe; engine captures eng_data.
- eng_clear  out  1  one-cycle strobe; engine zeroes its accumulator.
- eng_done  in  1  engine result valid pulse.
- eng_result  in  256  engine product, sampled when eng_done=1 in WAIT.

## Operation
- States: IDLE, CLEAR, LOAD_A, LOAD_B, WAIT, RESP.
- IDLE: grant = requester with valid. If both are valid, grant goes to the one not equal to the priority pointer `last`. req_ready[grant] = 1 combinationally in IDLE only. On accept, latch A, B, and id; `last` <= id; go to CLEAR.
- CLEAR: eng_clear=1 for one cycle -> LOAD_A.
- LOAD_A: eng_load=1, eng_data=latched A -> LOAD_B.
- LOAD_B: eng_load=1, eng_data=latched B -> WAIT. Timeout counter is cleared to 0.
- WAIT behaviour:
  - Counter increments each cycle.
  - eng_done=1: latch eng_result, resp_err <= 0, go to RESP.
  - Else if counter reaches TIMEOUT_CYC-1: resp_data <= 0, resp_err <= 1, go to RESP.
- RESP: resp_valid=1 with stable id/data/err. On resp_ready: job_count +1, go to IDLE.
- eng_data is 0 outside LOAD_A/LOAD_B. eng_done outside WAIT is ignored.
- Requester inputs are ignored outside IDLE. Only the latched copies drive the engine.
- job_count wraps modulo 2^CNT_W with no saturation.

## Timing
- Reset (nReset=0 at an edge): state IDLE, `last`=1 (so requester 0 wins the first tie).
  - Outputs: req*_ready=0 during reset, resp_valid=0, resp_id=0, resp_data=0, resp_err=0, busy=0, job_count=0, eng_data=0, eng_load=0, eng_clear=0.
- Reset mid-job abandons the job silently (no response). The engine is re-cleared by the next job's CLEAR.
- Cycle sequence after accept at edge 0:
  - CLEAR in cycle 1.
  - LOAD_A in cycle 2.
  - LOAD_B in cycle 3.
  - WAIT from cycle 4.
  - eng_done in WAIT cycle k puts resp_valid high from the next cycle.
- Minimum accept-to-resp_valid latency is 5 cycles (eng_done in the first WAIT cycle).
- Timeout: with no eng_done, resp_valid rises TIMEOUT_CYC+4 cycles after the accept edge.
- eng_done in the same cycle the counter hits its limit: done wins, resp_err=0.
- Back-to-back: resp accepted at edge n gives IDLE in cycle n+1, and a new accept is possible at edge n+1. Throughput is at most one job per 6 cycles.
- resp_valid must not drop and resp payload must not change until resp_ready.

## Test plan
- Single job, requester 0: A=identity, B has elements 1..16 row-major. Engine model asserts done 3 cycles into WAIT. Required: eng_clear in cycle 1, eng_load in cycles 2-3, resp_data=B, resp_id=0, resp_err=0, job_count=1.
- Both requesters valid continuously, four jobs. Required: grants 0,1,0,1, with each req_ready pulse lasting exactly one cycle.
- Timeout: TIMEOUT_CYC=8, engine never asserts done. Required: resp_valid at cycle 12 after accept, resp_err=1, resp_data=0.
- Done and timeout in the same cycle (done in WAIT cycle 7, TIMEOUT_CYC=8). Required: resp_err=0, data = engine result.
- Backpressure: hold resp_ready=0 for 10 cycles. Required: payload stable, busy=1, no req_ready, job_count unchanged until the handshake completes.
- Reset asserted during WAIT. Required: all outputs at reset values next cycle, no response. The next job completes normally, and job_count resumes from 0.
